// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU pipeline control blocks: sequencer state
// encoding, default halt-drain length and the hardwired zero register index.
package cpu_ctrl_pkg;

  // Cycles from HLT leaving ID until the core reports halted (EX, MEM, WB).
  localparam int DRAIN_CYCLES_DEF = 3;

  // r0 is hardwired to zero, so it never creates a data dependence.
  localparam logic [3:0] ZERO_REG = 4'h0;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_HALT_DRAIN = 2'd1,
    ST_HALTED     = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/hazard_lu_cmp.sv
// Load-use comparator: flags when the instruction in ID reads the
// destination of a load that is currently in EX. Kept separate so a
// forwarding unit can reuse the same compare.
module hazard_lu_cmp
  import cpu_ctrl_pkg::*;
(
  input  logic [3:0] id_rs,
  input  logic [3:0] id_rt,
  input  logic       id_rs_used,
  input  logic       id_rt_used,
  input  logic [3:0] ex_rd,
  input  logic       ex_regwrite,
  input  logic       ex_memtoreg,
  output logic       lu
);

  logic rs_hit;
  logic rt_hit;

  // Only operands actually read by ID can depend on the load.
  assign rs_hit = id_rs_used & (id_rs == ex_rd);
  assign rt_hit = id_rt_used & (id_rt == ex_rd);

  // A load into r0 writes nothing, so it can never stall.
  assign lu = ex_memtoreg & ex_regwrite & (ex_rd != ZERO_REG) & (rs_hit | rt_hit);

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline sequencing controller: load-use stall, taken-branch squash and
// the halt drain for the five-stage core.
// Optional build macro HAZARD_CTRL_PERF_EN adds 16-bit saturating
// load-use stall and branch flush counters; without it both count ports
// read zero and no counter flops exist.
//
// state         | meaning
// --------------+----------------------------------------------------------
// ST_RUN        | normal issue; resolves load-use, taken branch, HLT in ID
// ST_HALT_DRAIN | front end frozen, HLT and older work retire through EX..WB
// ST_HALTED     | core halted; only reset leaves
module hazard_ctrl_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  ID_reg_rs,
  input  logic [3:0]  ID_reg_rt,
  input  logic        ID_rs_used,
  input  logic        ID_rt_used,
  input  logic        ID_branch_taken,
  input  logic        ID_HLT,
  input  logic [3:0]  ID_EX_reg_rd,
  input  logic        ID_EX_RegWrite,
  input  logic        ID_EX_MemtoReg,
  output logic        PC_stall,
  output logic        IF_ID_stall,
  output logic        IF_ID_flush,
  output logic        ID_EX_flush,
  output logic        halted,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DRAIN_CYCLES - 1);

  ctrl_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          halted_q;
  logic          lu;
  logic          pc_stall_c, ifid_stall_c, ifid_flush_c, idex_flush_c;

  hazard_lu_cmp u_lu_cmp (
    .id_rs       (ID_reg_rs),
    .id_rt       (ID_reg_rt),
    .id_rs_used  (ID_rs_used),
    .id_rt_used  (ID_rt_used),
    .ex_rd       (ID_EX_reg_rd),
    .ex_regwrite (ID_EX_RegWrite),
    .ex_memtoreg (ID_EX_MemtoReg),
    .lu          (lu)
  );

  // Next state, drain counter and Mealy pipeline controls.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_stall_c   = 1'b0;
    ifid_stall_c = 1'b0;
    ifid_flush_c = 1'b0;
    idex_flush_c = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (lu) begin
          // Hold the front end one cycle and bubble EX; branch/HLT retried next cycle.
          pc_stall_c   = 1'b1;
          ifid_stall_c = 1'b1;
          idex_flush_c = 1'b1;
        end else if (ID_branch_taken) begin
          ifid_flush_c = 1'b1;
        end else if (ID_HLT) begin
          // HLT proceeds into ID/EX; nothing younger is allowed behind it.
          pc_stall_c   = 1'b1;
          ifid_flush_c = 1'b1;
          cnt_d        = '0;
          state_d      = ST_HALT_DRAIN;
        end
      end
      ST_HALT_DRAIN: begin
        pc_stall_c   = 1'b1;
        ifid_flush_c = 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_HALTED;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_HALTED: begin
        pc_stall_c   = 1'b1;
        ifid_flush_c = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // State, drain counter and sticky halted flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      cnt_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      halted_q <= (state_d == ST_HALTED);
    end
  end

  // Controls are forced low while reset is asserted, before the first edge.
  assign PC_stall    = rst_n & pc_stall_c;
  assign IF_ID_stall = rst_n & ifid_stall_c;
  assign IF_ID_flush = rst_n & ifid_flush_c;
  assign ID_EX_flush = rst_n & idex_flush_c;
  assign halted      = halted_q;

`ifdef HAZARD_CTRL_PERF_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] flush_cnt_q;
  logic        count_stall;
  logic        count_flush;

  assign count_stall = (state_q == ST_RUN) & lu;
  assign count_flush = (state_q == ST_RUN) & ~lu & ID_branch_taken;

  // Saturating event counters; frozen outside RUN.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= 16'h0000;
      flush_cnt_q <= 16'h0000;
    end else begin
      if (count_stall && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
      if (count_flush && (flush_cnt_q != 16'hFFFF)) begin
        flush_cnt_q <= flush_cnt_q + 16'd1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = 16'h0000;
  assign flush_cnt = 16'h0000;
`endif

endmodule
